// File: rtl/multibank_buffer_pkg.sv
// Shared types and helpers for the multi-bank ping-pong buffer.
package multibank_buffer_pkg;

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_st_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Word counts need one extra bit so a completely full bank is representable.
  function automatic int count_w(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/blk_mem.sv
// Simple dual-port block RAM, one write port, registered read port.
module blk_mem #(
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BIT_WIDTH-1:0]  wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [BIT_WIDTH-1:0]  rdata
);

  logic [BIT_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mbb_commit_queue.sv
// FIFO of committed {bank, count} entries; one slot per bank, so it cannot overflow.
module mbb_commit_queue
  import multibank_buffer_pkg::*;
#(
  parameter int BANK_W  = 2,
  parameter int COUNT_W = 9,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [BANK_W-1:0]  push_bank,
  input  logic [COUNT_W-1:0] push_cnt,
  input  logic               pop,
  output logic [BANK_W-1:0]  head_bank,
  output logic [COUNT_W-1:0] head_cnt,
  output logic               empty
);

  localparam int PW = clog2(DEPTH);

  logic [BANK_W-1:0]  bank_q [DEPTH];
  logic [COUNT_W-1:0] cnt_q  [DEPTH];
  logic [PW:0]        wp, rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      bank_q[wp[PW-1:0]] <= push_bank;
      cnt_q[wp[PW-1:0]]  <= push_cnt;
    end
  end

  assign empty     = (wp == rp);
  assign head_bank = bank_q[rp[PW-1:0]];
  assign head_cnt  = cnt_q[rp[PW-1:0]];

endmodule

// File: rtl/multibank_buffer.sv
// N-bank fill/commit/drain buffer: writer fills whole banks, reader drains them FWFT in commit order.
module multibank_buffer
  import multibank_buffer_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  ADDR_WIDTH = 8,
  parameter int  NUM_BANKS  = 4,
  localparam int BANK_W     = clog2(NUM_BANKS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [NUM_BANKS-1:0]  o_wr_ready,
  input  logic [NUM_BANKS-1:0]  i_wr_activate,
  input  logic                  i_wstrobe,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [15:0]           o_wr_fifo_size,
  output logic                  o_rd_ready,
  input  logic                  i_rd_activate,
  input  logic                  i_rstrobe,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [15:0]           o_rd_cnt,
  output logic [BANK_W-1:0]     o_rd_bank,
  output logic                  o_starved,
  output logic                  o_all_free,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_wr_err
);

  localparam int COUNT_W = count_w(ADDR_WIDTH);
  localparam int MEM_AW  = ADDR_WIDTH + BANK_W;
  localparam logic [COUNT_W-1:0] BANK_DEPTH = COUNT_W'(1 << ADDR_WIDTH);

  bank_st_e st [NUM_BANKS];

  // write side
  logic               filling, sel_legal, sel_err, commit, wr_en, ovf;
  logic [BANK_W-1:0]  wbank, sel_idx;
  logic [COUNT_W-1:0] wcnt;

  // read side
  logic               busy, was_act, fetch, live, rel, pop, adv, unf;
  logic [BANK_W-1:0]  rbank, q_bank;
  logic [COUNT_W-1:0] rcnt, rcons, rcons_nxt, q_cnt;
  logic [ADDR_WIDTH-1:0] disp;
  logic               q_empty;
  logic [DATA_WIDTH-1:0] mem_q;

  always_comb begin
    sel_idx = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (i_wr_activate[b]) sel_idx = BANK_W'(b);
    // A filling bank may only be continued; a new bank must be FREE and the select one-hot.
    sel_legal = $onehot(i_wr_activate) &&
                (filling ? (sel_idx == wbank) : (st[sel_idx] == B_FREE));
    sel_err   = (i_wr_activate != '0) && !sel_legal;
    commit    = filling && (i_wr_activate == '0);
    wr_en     = sel_legal && i_wstrobe && (wcnt != BANK_DEPTH);
    ovf       = sel_legal && i_wstrobe && (wcnt == BANK_DEPTH);
  end

  always_comb begin
    rel       = busy && was_act && !i_rd_activate;
    pop       = !q_empty && !i_rd_activate && (!busy || was_act);
    adv       = busy && i_rd_activate && i_rstrobe && (rcons != rcnt);
    unf       = busy && i_rd_activate && i_rstrobe && (rcons == rcnt);
    rcons_nxt = adv ? rcons + 1'b1 : rcons;
    // Past the end the last word stays on the output.
    disp      = (rcons_nxt < rcnt) ? ADDR_WIDTH'(rcons_nxt) : ADDR_WIDTH'(rcnt - 1'b1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      filling <= 1'b0;
      wbank   <= '0;
      wcnt    <= '0;
    end else if (commit) begin
      filling <= 1'b0;
      wcnt    <= '0;
    end else if (sel_legal) begin
      filling <= 1'b1;
      wbank   <= sel_idx;
      if (wr_en) wcnt <= wcnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy       <= 1'b0;
      was_act    <= 1'b0;
      fetch      <= 1'b0;
      live       <= 1'b0;
      o_rd_ready <= 1'b0;
      rbank      <= '0;
      rcnt       <= '0;
      rcons      <= '0;
    end else begin
      fetch      <= pop;
      o_rd_ready <= busy && !i_rd_activate && (fetch || o_rd_ready);
      if (pop) begin
        busy    <= 1'b1;
        was_act <= 1'b0;
        live    <= 1'b0;
        rbank   <= q_bank;
        rcnt    <= q_cnt;
        rcons   <= '0;
      end else if (rel) begin
        busy    <= 1'b0;
        was_act <= 1'b0;
        live    <= 1'b0;
      end else begin
        if (busy && i_rd_activate) was_act <= 1'b1;
        if (fetch) live <= 1'b1;
        rcons <= rcons_nxt;
      end
    end
  end

  // Writer-side and reader-side transitions always target distinct banks.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (i_rst) st[b] <= B_FREE;
      else begin
        if (sel_legal && !filling && sel_idx == BANK_W'(b)) st[b] <= B_FILLING;
        if (commit && wbank == BANK_W'(b)) st[b] <= (wcnt != '0) ? B_FULL : B_FREE;
        if (pop && q_bank == BANK_W'(b))   st[b] <= B_READING;
        if (rel && rbank == BANK_W'(b))    st[b] <= B_FREE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_wr_err    <= 1'b0;
    end else begin
      o_overflow  <= ovf;
      o_underflow <= unf;
      o_wr_err    <= sel_err;
    end
  end

  mbb_commit_queue #(.BANK_W(BANK_W), .COUNT_W(COUNT_W), .DEPTH(NUM_BANKS)) u_queue (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (commit && (wcnt != '0)),
    .push_bank (wbank),
    .push_cnt  (wcnt),
    .pop       (pop),
    .head_bank (q_bank),
    .head_cnt  (q_cnt),
    .empty     (q_empty)
  );

  blk_mem #(.BIT_WIDTH(DATA_WIDTH), .ADDR_WIDTH(MEM_AW)) u_mem (
    .clk   (i_clk),
    .we    (wr_en),
    .waddr ({sel_idx, ADDR_WIDTH'(wcnt)}),
    .wdata (i_wdata),
    .raddr ({rbank, disp}),
    .rdata (mem_q)
  );

  always_comb begin
    o_all_free = q_empty;
    for (int b = 0; b < NUM_BANKS; b++) begin
      o_wr_ready[b] = (st[b] == B_FREE);
      if (st[b] != B_FREE) o_all_free = 1'b0;
    end
  end

  assign o_wr_fifo_size = 16'(1 << ADDR_WIDTH);
  assign o_rdata        = live ? mem_q : '0;
  assign o_rd_cnt       = 16'(rcnt);
  assign o_rd_bank      = rbank;
  assign o_starved      = !o_rd_ready && !i_rd_activate;

endmodule

// File: tb/tb_multibank_buffer.sv
// Directed bench for multibank_buffer: expected read words are queued, a negedge monitor checks them.
module tb_multibank_buffer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [3:0] o_wr_ready;
  logic [3:0] i_wr_activate;
  logic       i_wstrobe;
  logic [7:0] i_wdata;
  logic [15:0] o_wr_fifo_size;
  logic       o_rd_ready;
  logic       i_rd_activate;
  logic       i_rstrobe;
  logic [7:0] o_rdata;
  logic [15:0] o_rd_cnt;
  logic [1:0] o_rd_bank;
  logic       o_starved, o_all_free, o_overflow, o_underflow, o_wr_err;

  int vectors = 0;
  int errors  = 0;
  int n_ovf = 0, n_unf = 0, n_err = 0;
  logic [7:0] exp_q [$];

  always #5 i_clk = ~i_clk;

  multibank_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_BANKS(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_wr_ready(o_wr_ready), .i_wr_activate(i_wr_activate),
    .i_wstrobe(i_wstrobe), .i_wdata(i_wdata), .o_wr_fifo_size(o_wr_fifo_size),
    .o_rd_ready(o_rd_ready), .i_rd_activate(i_rd_activate), .i_rstrobe(i_rstrobe),
    .o_rdata(o_rdata), .o_rd_cnt(o_rd_cnt), .o_rd_bank(o_rd_bank),
    .o_starved(o_starved), .o_all_free(o_all_free),
    .o_overflow(o_overflow), .o_underflow(o_underflow), .o_wr_err(o_wr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumed word is whatever o_rdata shows in a strobing cycle.
  always @(negedge i_clk) begin
    if (o_overflow)  n_ovf++;
    if (o_underflow) n_unf++;
    if (o_wr_err)    n_err++;
    if (!i_rst && i_rd_activate && i_rstrobe) begin
      if (exp_q.size() == 0) check("rdata_unexpected", {24'h0, o_rdata}, 32'hDEAD);
      else                   check("rdata", {24'h0, o_rdata}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_bank(input int b, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      i_wr_activate = 4'(1 << b);
      i_wstrobe     = 1'b1;
      i_wdata       = base + 8'(i);
      tick();
    end
    i_wstrobe     = 1'b0;
    i_wr_activate = '0;
    tick();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !o_rd_ready; i++) tick();
    check("rd_ready_wait", {31'h0, o_rd_ready}, 32'd1);
  endtask

  task automatic strobes(input int n);
    i_rd_activate = 1'b1;
    i_rstrobe     = 1'b1;
    for (int i = 0; i < n; i++) tick();
    i_rstrobe = 1'b0;
  endtask

  task automatic release_rd();
    i_rd_activate = 1'b0;
    i_rstrobe     = 1'b0;
    tick();
  endtask

  task automatic read_bank(input int bank, input int cnt, input logic [7:0] base);
    wait_ready();
    check("rd_bank", {30'h0, o_rd_bank}, 32'(bank));
    check("rd_cnt", {16'h0, o_rd_cnt}, 32'(cnt));
    for (int i = 0; i < cnt; i++) exp_q.push_back(base + 8'(i));
    strobes(cnt);
    release_rd();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    i_rst = 1'b1; i_wr_activate = '0; i_wstrobe = 1'b0; i_wdata = '0;
    i_rd_activate = 1'b0; i_rstrobe = 1'b0;
    tick(); tick();
    check("rst_wr_ready", {28'h0, o_wr_ready}, 32'hF);
    check("rst_rd_ready", {31'h0, o_rd_ready}, 32'd0);
    check("rst_rd_cnt", {16'h0, o_rd_cnt}, 32'd0);
    check("rst_rd_bank", {30'h0, o_rd_bank}, 32'd0);
    check("rst_rdata", {24'h0, o_rdata}, 32'd0);
    check("rst_all_free", {31'h0, o_all_free}, 32'd1);
    check("rst_starved", {31'h0, o_starved}, 32'd1);
    check("fifo_size", {16'h0, o_wr_fifo_size}, 32'd256);
    i_rst = 1'b0;
    tick();

    // Single bank: latency, FWFT stream, release.
    write_bank(0, 5, 8'h11);
    check("lat_commit", {31'h0, o_rd_ready}, 32'd0);
    tick();
    check("lat_pop", {31'h0, o_rd_ready}, 32'd0);
    tick();
    check("lat_data", {31'h0, o_rd_ready}, 32'd1);
    check("first_word", {24'h0, o_rdata}, 32'h11);
    check("rd_cnt_5", {16'h0, o_rd_cnt}, 32'd5);
    check("rd_bank_0", {30'h0, o_rd_bank}, 32'd0);
    check("wr_ready_busy", {28'h0, o_wr_ready}, 32'hE);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
    strobes(5);
    check("starved_reading", {31'h0, o_starved}, 32'd0);
    release_rd();
    check("wr_ready_released", {28'h0, o_wr_ready}, 32'hF);

    // Commit order 2, 0, 3 regardless of index.
    write_bank(2, 3, 8'h21);
    write_bank(0, 1, 8'h31);
    write_bank(3, 4, 8'h41);
    check("all_free_busy", {31'h0, o_all_free}, 32'd0);
    read_bank(2, 3, 8'h21);
    read_bank(0, 1, 8'h31);
    read_bank(3, 4, 8'h41);
    check("all_free_after", {31'h0, o_all_free}, 32'd1);

    // Overflow on strobe 257.
    e0 = n_ovf;
    write_bank(1, 257, 8'h00);
    check("ovf_pulses", 32'(n_ovf - e0), 32'd1);
    read_bank(1, 256, 8'h00);

    // Illegal selects.
    e0 = n_err;
    i_wr_activate = 4'b0011; i_wstrobe = 1'b1; i_wdata = 8'hEE;
    tick();
    i_wr_activate = '0; i_wstrobe = 1'b0;
    tick();
    check("err_multihot", 32'(n_err - e0), 32'd1);
    check("err_multihot_ready", {28'h0, o_wr_ready}, 32'hF);
    check("err_multihot_free", {31'h0, o_all_free}, 32'd1);
    write_bank(2, 2, 8'h51);
    wait_ready();
    check("wr_ready_reading", {28'h0, o_wr_ready}, 32'hB);
    i_wr_activate = 4'b0100; i_wstrobe = 1'b1; i_wdata = 8'hEE;
    tick();
    i_wr_activate = '0; i_wstrobe = 1'b0;
    tick();
    check("err_reading", 32'(n_err - e0), 32'd2);
    check("err_reading_ready", {28'h0, o_wr_ready}, 32'hB);
    check("err_reading_cnt", {16'h0, o_rd_cnt}, 32'd2);

    // Underflow: 3 strobes on the 2-word bank.
    e0 = n_unf;
    exp_q.push_back(8'h51); exp_q.push_back(8'h52); exp_q.push_back(8'h52);
    strobes(3);
    check("unf_pulse", {31'h0, o_underflow}, 32'd1);
    check("unf_hold", {24'h0, o_rdata}, 32'h52);
    release_rd();
    check("unf_count", 32'(n_unf - e0), 32'd1);
    check("unf_all_free", {31'h0, o_all_free}, 32'd1);

    // Reset mid-read and mid-fill.
    write_bank(3, 2, 8'h61);
    wait_ready();
    exp_q.push_back(8'h61);
    strobes(1);
    for (int i = 0; i < 7; i++) begin
      i_wr_activate = 4'b0010; i_wstrobe = 1'b1; i_wdata = 8'h70 + 8'(i);
      tick();
    end
    i_rst = 1'b1; i_wr_activate = '0; i_wstrobe = 1'b0; i_rd_activate = 1'b0;
    tick();
    i_rst = 1'b0;
    check("mid_rst_wr_ready", {28'h0, o_wr_ready}, 32'hF);
    check("mid_rst_rd_ready", {31'h0, o_rd_ready}, 32'd0);
    check("mid_rst_all_free", {31'h0, o_all_free}, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_rd_ready", {31'h0, o_rd_ready}, 32'd0);
    check("post_rst_rd_cnt", {16'h0, o_rd_cnt}, 32'd0);
    check("post_rst_all_free", {31'h0, o_all_free}, 32'd1);
    check("total_ovf", 32'(n_ovf), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
